// File: rtl/tile_match_ctrl_if.sv
// Tile RAM bus between the match controller and a dual-port tile memory.
// Ports A and B each carry an address, write data, a one-cycle write strobe,
// and read data that is valid one clock after the address is presented.
//   master : controller side (drives addr/wdata/we, samples rdata)
//   slave  : memory side    (samples addr/wdata/we, drives rdata)
interface tile_match_ctrl_if #(
  parameter int unsigned AW     = 4,
  parameter int unsigned TILE_W = 8
);
  logic [AW-1:0]     addr_a;
  logic [AW-1:0]     addr_b;
  logic [TILE_W-1:0] wdata_a;
  logic [TILE_W-1:0] wdata_b;
  logic              we_a;
  logic              we_b;
  logic [TILE_W-1:0] rdata_a;
  logic [TILE_W-1:0] rdata_b;

  modport master (
    output addr_a, addr_b, wdata_a, wdata_b, we_a, we_b,
    input  rdata_a, rdata_b
  );

  modport slave (
    input  addr_a, addr_b, wdata_a, wdata_b, we_a, we_b,
    output rdata_a, rdata_b
  );
endinterface

// File: rtl/tile_match_ctrl.sv
// Memory (pair matching) game controller over a COLS x ROWS tile RAM.
// Tile word: bit0 cursor, bit1 face-up, [TILE_W-1:2] symbol.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   game_on, quit          level controls; quit or !game_on returns to IDLE
//   btn_up..btn_select     raw button levels, rising edges detected here
//   ram (master)           dual-port tile RAM bus (addr/wdata/we out, rdata in)
//   moves, matched         completed pair attempts (saturating), pairs found
//   game_over, state       DONE indicator, debug state encoding
// Build option: define CURSOR_WRAP_EN to make the cursor wrap at grid edges;
// otherwise a move off the grid edge is ignored.
// RAM bus outputs are decoded from registered state plus rdata, because the
// read-modify-write steps must write in the cycle their read data returns.
module tile_match_ctrl #(
  parameter int unsigned COLS     = 4,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned TILE_W   = 8,
  parameter int unsigned HOLD_CYC = 100000000,
  localparam int unsigned AW      = $clog2(COLS * ROWS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                game_on,
  input  logic                quit,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_select,
  tile_match_ctrl_if.master   ram,
  output logic [7:0]          moves,
  output logic [AW-1:0]       matched,
  output logic                game_over,
  output logic [2:0]          state
);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned SW    = TILE_W - 2;
  localparam int unsigned PAIRS = COLS * ROWS / 2;
  localparam int unsigned HCW   = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_MOVE    = 3'd2,
    S_FLIP_RD = 3'd3,
    S_FLIP_WR = 3'd4,
    S_HOLD    = 3'd5,
    S_COMPARE = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_row, w_row_nxt, r_nrow, w_nrow_nxt;
  logic [CW-1:0]   r_col, w_col_nxt, r_ncol, w_ncol_nxt;
  logic            r_ph, w_ph_nxt;
  logic [7:0]      r_moves, w_moves_nxt;
  logic [AW-1:0]   r_matched, w_matched_nxt;
  logic [1:0]      r_picks, w_picks_nxt;
  logic [SW-1:0]   r_sym1, w_sym1_nxt, r_sym2, w_sym2_nxt;
  logic [AW-1:0]   r_loc1, w_loc1_nxt, r_loc2, w_loc2_nxt;
  logic [HCW-1:0]  r_hold, w_hold_nxt;
  logic [4:0]      r_btn_q;
  logic            r_game_over;
  logic [4:0]      w_btn, w_edge;
  logic            w_abort, w_mv;
  logic [AW-1:0]   w_cur, w_new;

  // Button order {select, right, left, down, up}; lower index wins among directions
  assign w_btn   = {btn_select, btn_right, btn_left, btn_down, btn_up};
  assign w_edge  = w_btn & ~r_btn_q;
  assign w_abort = quit | ~game_on;
  assign w_cur   = AW'(r_row) * AW'(COLS) + AW'(r_col);
  assign w_new   = AW'(r_nrow) * AW'(COLS) + AW'(r_ncol);

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_nrow      <= '0;
      r_ncol      <= '0;
      r_ph        <= 1'b0;
      r_moves     <= '0;
      r_matched   <= '0;
      r_picks     <= '0;
      r_sym1      <= '0;
      r_sym2      <= '0;
      r_loc1      <= '0;
      r_loc2      <= '0;
      r_hold      <= '0;
      r_btn_q     <= '0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_nrow      <= w_nrow_nxt;
      r_ncol      <= w_ncol_nxt;
      r_ph        <= w_ph_nxt;
      r_moves     <= w_moves_nxt;
      r_matched   <= w_matched_nxt;
      r_picks     <= w_picks_nxt;
      r_sym1      <= w_sym1_nxt;
      r_sym2      <= w_sym2_nxt;
      r_loc1      <= w_loc1_nxt;
      r_loc2      <= w_loc2_nxt;
      r_hold      <= w_hold_nxt;
      r_btn_q     <= w_btn;
      r_game_over <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state, datapath updates and RAM bus decode
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_nrow_nxt    = r_nrow;
    w_ncol_nxt    = r_ncol;
    w_ph_nxt      = r_ph;
    w_moves_nxt   = r_moves;
    w_matched_nxt = r_matched;
    w_picks_nxt   = r_picks;
    w_sym1_nxt    = r_sym1;
    w_sym2_nxt    = r_sym2;
    w_loc1_nxt    = r_loc1;
    w_loc2_nxt    = r_loc2;
    w_hold_nxt    = r_hold;
    w_mv          = 1'b0;
    ram.addr_a    = '0;
    ram.addr_b    = '0;
    ram.wdata_a   = '0;
    ram.wdata_b   = '0;
    ram.we_a      = 1'b0;
    ram.we_b      = 1'b0;

    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt   = S_SELECT;
          w_moves_nxt   = '0;
          w_matched_nxt = '0;
          w_row_nxt     = '0;
          w_col_nxt     = '0;
          w_picks_nxt   = '0;
        end
        S_SELECT: begin
          w_nrow_nxt = r_row;
          w_ncol_nxt = r_col;
          // Any direction edge consumes the cycle, even if blocked at the edge
          if (w_edge[0]) begin
            if (r_row != '0) begin
              w_nrow_nxt = r_row - RW'(1);
              w_mv       = 1'b1;
            end
`ifdef CURSOR_WRAP_EN
            else begin
              w_nrow_nxt = RW'(ROWS - 1);
              w_mv       = 1'b1;
            end
`endif
          end else if (w_edge[1]) begin
            if (r_row != RW'(ROWS - 1)) begin
              w_nrow_nxt = r_row + RW'(1);
              w_mv       = 1'b1;
            end
`ifdef CURSOR_WRAP_EN
            else begin
              w_nrow_nxt = '0;
              w_mv       = 1'b1;
            end
`endif
          end else if (w_edge[2]) begin
            if (r_col != '0) begin
              w_ncol_nxt = r_col - CW'(1);
              w_mv       = 1'b1;
            end
`ifdef CURSOR_WRAP_EN
            else begin
              w_ncol_nxt = CW'(COLS - 1);
              w_mv       = 1'b1;
            end
`endif
          end else if (w_edge[3]) begin
            if (r_col != CW'(COLS - 1)) begin
              w_ncol_nxt = r_col + CW'(1);
              w_mv       = 1'b1;
            end
`ifdef CURSOR_WRAP_EN
            else begin
              w_ncol_nxt = '0;
              w_mv       = 1'b1;
            end
`endif
          end else if (w_edge[4]) begin
            w_state_nxt = S_FLIP_RD;
          end
          if (w_mv) begin
            w_state_nxt = S_MOVE;
            w_ph_nxt    = 1'b0;
          end
        end
        S_MOVE: begin
          ram.addr_a = w_cur;
          ram.addr_b = w_new;
          if (!r_ph) begin
            w_ph_nxt = 1'b1;
          end else begin
            // Read data for both tiles is back: move the cursor bit
            ram.we_a    = 1'b1;
            ram.we_b    = 1'b1;
            ram.wdata_a = ram.rdata_a & ~TILE_W'(1);
            ram.wdata_b = ram.rdata_b | TILE_W'(1);
            w_row_nxt   = r_nrow;
            w_col_nxt   = r_ncol;
            w_state_nxt = S_SELECT;
          end
        end
        S_FLIP_RD: begin
          ram.addr_a  = w_cur;
          w_state_nxt = S_FLIP_WR;
        end
        S_FLIP_WR: begin
          ram.addr_a  = w_cur;
          w_state_nxt = S_SELECT;
          if (!ram.rdata_a[1] && !(r_picks == 2'd1 && w_cur == r_loc1)) begin
            ram.we_a    = 1'b1;
            ram.wdata_a = ram.rdata_a | TILE_W'(2);
            if (r_picks == 2'd0) begin
              w_sym1_nxt  = ram.rdata_a[TILE_W-1:2];
              w_loc1_nxt  = w_cur;
              w_picks_nxt = 2'd1;
            end else begin
              w_sym2_nxt  = ram.rdata_a[TILE_W-1:2];
              w_loc2_nxt  = w_cur;
              w_picks_nxt = 2'd2;
              w_hold_nxt  = '0;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (r_hold == HCW'(HOLD_CYC - 1)) begin
            w_state_nxt = S_COMPARE;
          end else begin
            w_hold_nxt = r_hold + HCW'(1);
          end
        end
        S_COMPARE: begin
          w_moves_nxt = (r_moves == 8'hFF) ? r_moves : r_moves + 8'd1;
          w_picks_nxt = '0;
          w_state_nxt = S_SELECT;
          if (r_sym1 == r_sym2) begin
            w_matched_nxt = r_matched + AW'(1);
            if (w_matched_nxt == AW'(PAIRS)) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            // Tile words rebuilt from latched symbols: face-down, cursor kept
            ram.addr_a  = r_loc1;
            ram.addr_b  = r_loc2;
            ram.we_a    = 1'b1;
            ram.we_b    = 1'b1;
            ram.wdata_a = {r_sym1, 1'b0, (r_loc1 == w_cur)};
            ram.wdata_b = {r_sym2, 1'b0, (r_loc2 == w_cur)};
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign moves     = r_moves;
  assign matched   = r_matched;
  assign game_over = r_game_over;
  assign state     = r_state;
endmodule

// File: doc/tile_match_ctrl.md
TILE_MATCH_CTRL -- requirements
Module: tile_match_ctrl

Interface
REQ-001 Parameter COLS, default 4, grid columns (2..16).
REQ-002 Parameter ROWS, default 4, grid rows (2..16); COLS*ROWS even.
REQ-003 Parameter TILE_W, default 8, tile word width; bit0 cursor, bit1 face-up, [TILE_W-1:2] symbol.
REQ-004 Parameter HOLD_CYC, default 100000000, mismatch display time in clk cycles (>=1).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 game_on  in  1  level; game enabled.
REQ-008 quit  in  1  level; abandon game.
REQ-009 btn_up, btn_down, btn_left, btn_right, btn_select  in  1 each  raw levels, rising-edge detected internally.
REQ-010 addr_a, addr_b  out  AW=clog2(COLS*ROWS)  tile RAM port addresses.
REQ-011 wdata_a, wdata_b  out  TILE_W  write data; we_a, we_b  out  1  one-cycle write strobes.
REQ-012 rdata_a, rdata_b  in  TILE_W  RAM read data, valid 1 cycle after address.
REQ-013 moves  out  8  completed pair attempts; matched  out  AW  pairs found; game_over  out  1; state  out  3  debug.

Function
REQ-014 States: IDLE, SELECT, MOVE, FLIP_RD, FLIP_WR, HOLD, COMPARE, DONE.
REQ-015 IDLE -> SELECT when game_on=1; entering SELECT from IDLE clears moves, matched, cursor=0, pick count=0.
REQ-016 quit=1 or game_on=0 in any state -> IDLE next cycle, no write issued that cycle.
REQ-017 SELECT: direction edge -> MOVE with new cursor computed per REQ-026; select edge -> FLIP_RD; direction has priority over select on same cycle; among directions priority up, down, left, right.
REQ-018 MOVE: cycle 1 drive addr_a=old, addr_b=new; cycle 2 write old with bit0=0, new with bit0=1 (we_a, we_b both 1); then SELECT; 2 cycles total, same read-modify-write on bits [TILE_W-1:1].
REQ-019 FLIP_RD: addr_a=cursor one cycle; FLIP_WR samples rdata_a.
REQ-020 FLIP_WR: tile already face-up or cursor equals first pick -> SELECT, no write; else write rdata_a|2'b10 via port A, latch symbol and location, pick count+1.
REQ-021 After first pick -> SELECT; after second pick -> HOLD.
REQ-022 HOLD: counts HOLD_CYC cycles from entry, then COMPARE; buttons ignored.
REQ-023 COMPARE (1 cycle): moves+1 saturating at 255; symbols equal -> matched+1, tiles stay face-up; else both tiles written with bits[1:0] cleared except cursor tile keeps bit0=1; pick count=0.
REQ-024 COMPARE -> DONE when matched reaches COLS*ROWS/2, else SELECT; game_over=1 only in DONE.
REQ-025 DONE: holds until quit or game_on=0; no writes.
REQ-026 Cursor bounds: row/col arithmetic, never raw address ± offset; behaviour at edge per REQ-031.
REQ-027 we_a/we_b never asserted outside MOVE cycle 2, FLIP_WR, COMPARE.

Reset
REQ-028 resetn=0 asynchronously forces IDLE, cursor=0, moves=0, matched=0, pick count=0, hold counter=0, edge-detect history=0.
REQ-029 During reset: we_a=we_b=0, addr=0, wdata=0, game_over=0, state=IDLE encoding 3'b000.
REQ-030 Reset mid-HOLD or mid-MOVE discards operation; no partial write after release.

Configuration
REQ-031 Macro CURSOR_WRAP_EN: defined -> cursor wraps (left of col 0 -> col COLS-1 same row, up of row 0 -> row ROWS-1); undefined -> move at edge ignored, stays in SELECT, no MOVE, no writes.

Verification
REQ-032 Reset, game_on=1, right edge -> addr_a=0, addr_b=1, cycle 2 wdata_a bit0=0, wdata_b bit0=1, we both 1.
REQ-033 Cursor 0, left edge: without CURSOR_WRAP_EN no write, cursor 0; with it cursor 3 (COLS=4).
REQ-034 Select tiles 0 and 5 with equal symbols -> after HOLD_CYC(=10 bench) COMPARE, matched=1, moves=1, no clear writes.
REQ-035 Select mismatched tiles 0,1 -> COMPARE writes both with bit1=0; moves=1, matched=0.
REQ-036 Select same tile twice -> second ignored, pick count stays 1; match all 8 pairs -> game_over=1 in DONE.
REQ-037 resetn pulsed low during HOLD -> IDLE immediately, moves=0, no writes after release.
